// File: rtl/mem_ctrl_arb.sv
// Byte-serial memory controller arbitrating icache line fills and LSB loads/stores
// onto a single-port, one-byte-per-cycle RAM/IO bus.
module mem_ctrl_arb #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          LINE_BYTES = 4,
    parameter int unsigned IO_BASE    = 32'h30000,
    parameter int          FAIR       = 0
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic                    if_done,
    output logic [LINE_BYTES*8-1:0] if_data,
    input  logic                    lsb_req,
    input  logic                    lsb_wr,
    input  logic [ADDR_WIDTH-1:0]   lsb_addr,
    input  logic [1:0]              lsb_size,
    input  logic                    lsb_signed,
    input  logic [31:0]             lsb_wdata,
    output logic                    lsb_done,
    output logic [31:0]             lsb_rdata,
    output logic                    busy
);
    localparam int IW = $clog2(LINE_BYTES + 1);
    localparam logic [ADDR_WIDTH-1:0] IO_BASE_A = ADDR_WIDTH'(IO_BASE);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   base;
    logic [IW-1:0]           nbytes;
    logic [IW-1:0]           iss;
    logic [IW-1:0]           cap;
    logic                    pend;
    logic                    is_lsb;
    logic                    rr_if;
    logic                    sgn;
    logic [1:0]              size_q;
    logic [31:0]             wdata;
    logic [LINE_BYTES*8-1:0] line;
    logic [LINE_BYTES*8-1:0] line_nx;
    logic [ADDR_WIDTH-1:0]   iss_addr;
    logic                    io_stall;
    logic                    grant_lsb;
    logic [IW-1:0]           size_n;

    function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] sz,
                                             input logic sg);
        case (sz)
            2'b00:   return {{24{sg & raw[7]}}, raw[7:0]};
            2'b01:   return {{16{sg & raw[15]}}, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    assign iss_addr  = base + ADDR_WIDTH'(iss);
    assign io_stall  = (state == WR) && (iss_addr >= IO_BASE_A) && io_buffer_full;
    // rr_if set means the icache is favoured on the next contested grant
    assign grant_lsb = lsb_req && (!if_req || (FAIR == 0) || !rr_if);
    assign busy      = (state != IDLE);

    always_comb begin
        case (lsb_size)
            2'b00:   size_n = IW'(1);
            2'b01:   size_n = IW'(2);
            default: size_n = IW'(4);
        endcase
    end

    always_comb begin
        line_nx = line;
        for (int k = 0; k < LINE_BYTES; k++) begin
            if (IW'(k) == cap) line_nx[8*k +: 8] = mem_din;
        end
    end

    always_comb begin
        mem_a    = '0;
        mem_wr   = 1'b0;
        mem_dout = 8'h00;
        if (state == RD && iss < nbytes) begin
            mem_a = iss_addr;
        end else if (state == WR && !io_stall) begin
            mem_a    = iss_addr;
            mem_wr   = rdy_in;
            mem_dout = wdata[{iss[1:0], 3'b000} +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state     <= IDLE;
            iss       <= '0;
            cap       <= '0;
            nbytes    <= '0;
            pend      <= 1'b0;
            is_lsb    <= 1'b0;
            rr_if     <= 1'b0;
            if_done   <= 1'b0;
            lsb_done  <= 1'b0;
            if_data   <= '0;
            lsb_rdata <= '0;
        end else begin
            if_done  <= 1'b0;
            lsb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rdy_in && !flush && (if_req || lsb_req)) begin
                        is_lsb <= grant_lsb;
                        rr_if  <= grant_lsb;
                        base   <= grant_lsb ? lsb_addr : if_addr;
                        nbytes <= grant_lsb ? size_n : IW'(LINE_BYTES);
                        sgn    <= lsb_signed;
                        size_q <= lsb_size;
                        wdata  <= lsb_wdata;
                        iss    <= '0;
                        cap    <= '0;
                        pend   <= 1'b0;
                        state  <= (grant_lsb && lsb_wr) ? WR : RD;
                    end
                end
                RD: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (!rdy_in) begin
                        // the byte in flight is lost; re-issue from the oldest uncaptured one
                        iss  <= cap;
                        pend <= 1'b0;
                    end else begin
                        pend <= (iss < nbytes);
                        if (iss < nbytes) iss <= iss + IW'(1);
                        if (pend) begin
                            line <= line_nx;
                            cap  <= cap + IW'(1);
                            if (cap == nbytes - IW'(1)) begin
                                state <= DONE;
                                if (is_lsb) begin
                                    lsb_done  <= 1'b1;
                                    lsb_rdata <= load_ext(line_nx[31:0], size_q, sgn);
                                end else begin
                                    if_done <= 1'b1;
                                    if_data <= line_nx;
                                end
                            end
                        end
                    end
                end
                WR: begin
                    // stores are committed, so flush does not interrupt them
                    if (rdy_in && !io_stall) begin
                        iss <= iss + IW'(1);
                        if (iss == nbytes - IW'(1)) begin
                            state    <= DONE;
                            lsb_done <= 1'b1;
                        end
                    end
                end
                // done pulse is already out; leave even when stalled so it stays one cycle
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed self-checking bench: dut 0 is FAIR=0 / 4-byte lines, dut 1 is FAIR=1 / 16-byte lines.
module tb_mem_ctrl_arb;
    logic clk = 1'b0;
    logic rst_in, rdy_in, flush, iobf;
    logic        if_req    [2];
    logic [31:0] if_addr   [2];
    logic        lsb_req   [2];
    logic        lsb_wr    [2];
    logic [31:0] lsb_addr  [2];
    logic [1:0]  lsb_size  [2];
    logic        lsb_signed[2];
    logic [31:0] lsb_wdata [2];
    logic [7:0]  mem_din   [2];
    logic [7:0]  mem_dout  [2];
    logic [31:0] mem_a     [2];
    logic        mem_wr    [2];
    logic        if_done   [2];
    logic        lsb_done  [2];
    logic [31:0] lsb_rdata [2];
    logic        busy      [2];
    logic [31:0]  if_data0;
    logic [127:0] if_data1;
    logic [7:0]  ram [2][4096];
    int checks = 0;
    int errors = 0;
    int both_done = 0;

    always #5 clk = ~clk;

    mem_ctrl_arb #(.ADDR_WIDTH(32), .LINE_BYTES(4), .IO_BASE(32'h30000), .FAIR(0)) dut0 (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(iobf),
        .mem_din(mem_din[0]), .mem_dout(mem_dout[0]), .mem_a(mem_a[0]), .mem_wr(mem_wr[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_done(if_done[0]), .if_data(if_data0),
        .lsb_req(lsb_req[0]), .lsb_wr(lsb_wr[0]), .lsb_addr(lsb_addr[0]), .lsb_size(lsb_size[0]),
        .lsb_signed(lsb_signed[0]), .lsb_wdata(lsb_wdata[0]), .lsb_done(lsb_done[0]),
        .lsb_rdata(lsb_rdata[0]), .busy(busy[0]));

    mem_ctrl_arb #(.ADDR_WIDTH(32), .LINE_BYTES(16), .IO_BASE(32'h30000), .FAIR(1)) dut1 (
        .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .io_buffer_full(iobf),
        .mem_din(mem_din[1]), .mem_dout(mem_dout[1]), .mem_a(mem_a[1]), .mem_wr(mem_wr[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_done(if_done[1]), .if_data(if_data1),
        .lsb_req(lsb_req[1]), .lsb_wr(lsb_wr[1]), .lsb_addr(lsb_addr[1]), .lsb_size(lsb_size[1]),
        .lsb_signed(lsb_signed[1]), .lsb_wdata(lsb_wdata[1]), .lsb_done(lsb_done[1]),
        .lsb_rdata(lsb_rdata[1]), .busy(busy[1]));

    // synchronous-read RAM: data for the address driven in cycle t appears in cycle t+1
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) mem_din[i] <= ram[i][mem_a[i][11:0]];
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) if (if_done[i] && lsb_done[i]) both_done++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            if_req[i] = 0; if_addr[i] = 0; lsb_req[i] = 0; lsb_wr[i] = 0;
            lsb_addr[i] = 0; lsb_size[i] = 0; lsb_signed[i] = 0; lsb_wdata[i] = 0;
        end
        rdy_in = 1; flush = 0; iobf = 0;
    endtask

    task automatic test_reset();
        rst_in = 1;
        idle_inputs();
        lsb_req[0] = 1; lsb_addr[0] = 32'h100; lsb_size[0] = 2;
        repeat (3) cyc();
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (mem_a[i] !== 0 || mem_wr[i] !== 0 || mem_dout[i] !== 0 || busy[i] !== 0 ||
                if_done[i] !== 0 || lsb_done[i] !== 0 || lsb_rdata[i] !== 0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: a=%h wr=%b dout=%h busy=%b ifd=%b lsbd=%b rdata=%h, required all 0",
                         i, mem_a[i], mem_wr[i], mem_dout[i], busy[i], if_done[i], lsb_done[i], lsb_rdata[i]);
            end
        end
        checks++;
        if (if_data0 !== 0 || if_data1 !== 0) begin
            errors++;
            $display("FAIL reset_if_data: %h %h, required 0", if_data0, if_data1);
        end
        lsb_req[0] = 0;
        rst_in = 0;
        repeat (2) cyc();
    endtask

    task automatic test_load_word();
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 0; lsb_addr[0] = 32'h100; lsb_size[0] = 2'b10; lsb_signed[0] = 0;
        for (int c = 1; c <= 7; c++) begin
            cyc();
            #1;
            if (c <= 4) begin
                checks++;
                if (mem_a[0] !== 32'h100 + c - 1 || mem_wr[0] !== 0) begin
                    errors++;
                    $display("FAIL load_word_addr c%0d: a=%h wr=%b, required a=%h wr=0", c, mem_a[0], mem_wr[0], 32'h100 + c - 1);
                end
            end
            checks++;
            if (lsb_done[0] !== (c == 6)) begin
                errors++;
                $display("FAIL load_word_done c%0d: %b, required %b", c, lsb_done[0], c == 6);
            end
            if (c >= 6) begin
                checks++;
                if (lsb_rdata[0] !== 32'h44332211) begin
                    errors++;
                    $display("FAIL load_word_data c%0d: %h, required 44332211", c, lsb_rdata[0]);
                end
            end
            if (c == 6) lsb_req[0] = 0;
        end
        checks++;
        if (busy[0] !== 0) begin
            errors++;
            $display("FAIL load_word_idle: busy=%b, required 0", busy[0]);
        end
    endtask

    task automatic test_sign_ext();
        logic [31:0] addr_t [4] = '{32'h200, 32'h200, 32'h202, 32'h202};
        logic [1:0]  size_t [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        sgn_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_t  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF234, 32'h0000F234};
        for (int t = 0; t < 4; t++) begin
            int n;
            n = (size_t[t] == 2'b00) ? 1 : 2;
            cyc();
            lsb_req[0] = 1; lsb_wr[0] = 0; lsb_addr[0] = addr_t[t]; lsb_size[0] = size_t[t];
            lsb_signed[0] = sgn_t[t];
            for (int c = 1; c <= n + 2; c++) begin
                cyc();
                #1;
                if (c == n + 2) begin
                    checks++;
                    if (lsb_done[0] !== 1 || lsb_rdata[0] !== exp_t[t]) begin
                        errors++;
                        $display("FAIL sign_ext t%0d: done=%b data=%h, required done=1 data=%h", t, lsb_done[0], lsb_rdata[0], exp_t[t]);
                    end
                    lsb_req[0] = 0;
                end
            end
            cyc();
        end
    endtask

    task automatic test_io_store();
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 1; lsb_addr[0] = 32'h30000; lsb_size[0] = 2'b00; lsb_wdata[0] = 32'h00000041;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            iobf = (c <= 3);
            #1;
            if (c <= 3) begin
                checks++;
                if (mem_wr[0] !== 0 || mem_a[0] !== 0 || lsb_done[0] !== 0) begin
                    errors++;
                    $display("FAIL io_stall c%0d: wr=%b a=%h done=%b, required all 0", c, mem_wr[0], mem_a[0], lsb_done[0]);
                end
            end else if (c == 4) begin
                checks++;
                if (mem_wr[0] !== 1 || mem_a[0] !== 32'h30000 || mem_dout[0] !== 8'h41 || lsb_done[0] !== 0) begin
                    errors++;
                    $display("FAIL io_write: wr=%b a=%h dout=%h done=%b, required 1 30000 41 0", mem_wr[0], mem_a[0], mem_dout[0], lsb_done[0]);
                end
            end else begin
                checks++;
                if (lsb_done[0] !== 1 || mem_wr[0] !== 0) begin
                    errors++;
                    $display("FAIL io_done: done=%b wr=%b, required 1 0", lsb_done[0], mem_wr[0]);
                end
                lsb_req[0] = 0;
            end
        end
        cyc();
    endtask

    task automatic test_store_word();
        logic [31:0] wd;
        wd = 32'hDDCCBBAA;
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 1; lsb_addr[0] = 32'h40; lsb_size[0] = 2'b11; lsb_wdata[0] = wd;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            #1;
            if (c <= 4) begin
                checks++;
                if (mem_wr[0] !== 1 || mem_a[0] !== 32'h40 + c - 1 || mem_dout[0] !== wd[8*(c-1) +: 8] || lsb_done[0] !== 0) begin
                    errors++;
                    $display("FAIL store_word c%0d: wr=%b a=%h dout=%h done=%b, required 1 %h %h 0",
                             c, mem_wr[0], mem_a[0], mem_dout[0], lsb_done[0], 32'h40 + c - 1, wd[8*(c-1) +: 8]);
                end
            end else begin
                checks++;
                if (lsb_done[0] !== 1 || mem_wr[0] !== 0) begin
                    errors++;
                    $display("FAIL store_word_done: done=%b wr=%b, required 1 0", lsb_done[0], mem_wr[0]);
                end
                lsb_req[0] = 0;
            end
        end
        cyc();
    endtask

    task automatic test_rdy_stall();
        logic [31:0] exp_a [8] = '{32'h100, 32'h101, 32'h0, 32'h101, 32'h102, 32'h103, 32'h0, 32'h0};
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 0; lsb_addr[0] = 32'h100; lsb_size[0] = 2'b10; lsb_signed[0] = 0;
        for (int c = 1; c <= 8; c++) begin
            cyc();
            rdy_in = (c != 3);
            #1;
            if (c == 3) begin
                checks++;
                if (mem_wr[0] !== 0) begin
                    errors++;
                    $display("FAIL stall_wr: %b, required 0", mem_wr[0]);
                end
            end else begin
                checks++;
                if (mem_a[0] !== exp_a[c-1]) begin
                    errors++;
                    $display("FAIL stall_addr c%0d: %h, required %h", c, mem_a[0], exp_a[c-1]);
                end
            end
            checks++;
            if (lsb_done[0] !== (c == 8)) begin
                errors++;
                $display("FAIL stall_done c%0d: %b, required %b", c, lsb_done[0], c == 8);
            end
            if (c == 8) begin
                checks++;
                if (lsb_rdata[0] !== 32'h44332211) begin
                    errors++;
                    $display("FAIL stall_data: %h, required 44332211", lsb_rdata[0]);
                end
                lsb_req[0] = 0;
            end
        end
        cyc();
    endtask

    task automatic test_fair_rr();
        int ev;
        int got [4];
        int exp_k [4] = '{1, 2, 1, 2};
        logic [127:0] exp_line;
        for (int k = 0; k < 16; k++) exp_line[8*k +: 8] = 8'hA0 + 8'(k);
        ev = 0;
        cyc();
        if_req[1] = 1; if_addr[1] = 32'h400;
        lsb_req[1] = 1; lsb_wr[1] = 0; lsb_addr[1] = 32'h100; lsb_size[1] = 2'b10; lsb_signed[1] = 0;
        for (int c = 0; c < 200 && ev < 4; c++) begin
            cyc();
            #1;
            if (lsb_done[1] || if_done[1]) begin
                got[ev] = lsb_done[1] ? 1 : 2;
                checks++;
                if (lsb_done[1] ? (lsb_rdata[1] !== 32'h44332211) : (if_data1 !== exp_line)) begin
                    errors++;
                    $display("FAIL rr_data ev%0d: rdata=%h line=%h", ev, lsb_rdata[1], if_data1);
                end
                ev++;
            end
        end
        if_req[1] = 0; lsb_req[1] = 0;
        checks++;
        if (ev !== 4) begin
            errors++;
            $display("FAIL rr_events: %0d transactions seen, required 4", ev);
        end
        for (int i = 0; i < ev; i++) begin
            checks++;
            if (got[i] !== exp_k[i]) begin
                errors++;
                $display("FAIL rr_order ev%0d: %0d, required %0d (1=LSB 2=IF)", i, got[i], exp_k[i]);
            end
        end
        repeat (2) cyc();
    endtask

    task automatic test_fixed_prio();
        int ev;
        int got [4];
        int exp_k [4] = '{1, 1, 1, 2};
        ev = 0;
        cyc();
        if_req[0] = 1; if_addr[0] = 32'h400;
        lsb_req[0] = 1; lsb_wr[0] = 0; lsb_addr[0] = 32'h100; lsb_size[0] = 2'b10; lsb_signed[0] = 0;
        for (int c = 0; c < 100 && ev < 4; c++) begin
            cyc();
            #1;
            if (lsb_done[0] || if_done[0]) begin
                got[ev] = lsb_done[0] ? 1 : 2;
                if (if_done[0]) begin
                    checks++;
                    if (if_data0 !== 32'h53525150) begin
                        errors++;
                        $display("FAIL prio_fill_data: %h, required 53525150", if_data0);
                    end
                end
                ev++;
                if (ev == 3) lsb_req[0] = 0;
            end
        end
        if_req[0] = 0; lsb_req[0] = 0;
        checks++;
        if (ev !== 4) begin
            errors++;
            $display("FAIL prio_events: %0d transactions seen, required 4", ev);
        end
        for (int i = 0; i < ev; i++) begin
            checks++;
            if (got[i] !== exp_k[i]) begin
                errors++;
                $display("FAIL prio_order ev%0d: %0d, required %0d (1=LSB 2=IF)", i, got[i], exp_k[i]);
            end
        end
        repeat (2) cyc();
    endtask

    task automatic test_flush();
        cyc();
        if_req[1] = 1; if_addr[1] = 32'h400;
        for (int c = 1; c <= 25; c++) begin
            cyc();
            flush = (c == 5 || c == 6);
            #1;
            checks++;
            if (if_done[1] !== (c == 25)) begin
                errors++;
                $display("FAIL flush_done c%0d: %b, required %b", c, if_done[1], c == 25);
            end
            if (c == 6 || c == 7) begin
                checks++;
                if (busy[1] !== 0 || mem_a[1] !== 0) begin
                    errors++;
                    $display("FAIL flush_idle c%0d: busy=%b a=%h, required 0 0", c, busy[1], mem_a[1]);
                end
            end
            if (c == 8) begin
                checks++;
                if (busy[1] !== 1 || mem_a[1] !== 32'h400) begin
                    errors++;
                    $display("FAIL flush_regrant: busy=%b a=%h, required 1 400", busy[1], mem_a[1]);
                end
            end
            if (c == 25) if_req[1] = 0;
        end
        flush = 0;
        cyc();
    endtask

    task automatic test_back_to_back();
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 0; lsb_addr[0] = 32'h100; lsb_size[0] = 2'b10; lsb_signed[0] = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            #1;
            if (c == 6) begin
                lsb_addr[0] = 32'h200; lsb_size[0] = 2'b00;
            end
            if (c == 7) begin
                checks++;
                if (busy[0] !== 0 || lsb_done[0] !== 0) begin
                    errors++;
                    $display("FAIL b2b_bubble: busy=%b done=%b, required 0 0", busy[0], lsb_done[0]);
                end
            end
            if (c == 8) begin
                checks++;
                if (mem_a[0] !== 32'h200) begin
                    errors++;
                    $display("FAIL b2b_addr: %h, required 200", mem_a[0]);
                end
            end
            if (c == 10) begin
                checks++;
                if (lsb_done[0] !== 1 || lsb_rdata[0] !== 32'h00000080) begin
                    errors++;
                    $display("FAIL b2b_second: done=%b data=%h, required 1 00000080", lsb_done[0], lsb_rdata[0]);
                end
                lsb_req[0] = 0;
            end
        end
        cyc();
    endtask

    task automatic test_reset_abort();
        cyc();
        lsb_req[0] = 1; lsb_wr[0] = 1; lsb_addr[0] = 32'h40; lsb_size[0] = 2'b10; lsb_wdata[0] = 32'h12345678;
        cyc();
        cyc();
        #1;
        checks++;
        if (mem_wr[0] !== 1 || mem_a[0] !== 32'h41) begin
            errors++;
            $display("FAIL abort_pre: wr=%b a=%h, required 1 41", mem_wr[0], mem_a[0]);
        end
        rst_in = 1;
        lsb_req[0] = 0;
        cyc();
        #1;
        checks++;
        if (mem_wr[0] !== 0 || mem_a[0] !== 0 || busy[0] !== 0 || lsb_done[0] !== 0) begin
            errors++;
            $display("FAIL abort_post: wr=%b a=%h busy=%b done=%b, required all 0", mem_wr[0], mem_a[0], busy[0], lsb_done[0]);
        end
        rst_in = 0;
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) for (int a = 0; a < 4096; a++) ram[i][a] = 8'h00;
        for (int i = 0; i < 2; i++) begin
            ram[i][12'h100] = 8'h11; ram[i][12'h101] = 8'h22;
            ram[i][12'h102] = 8'h33; ram[i][12'h103] = 8'h44;
            ram[i][12'h200] = 8'h80; ram[i][12'h202] = 8'h34; ram[i][12'h203] = 8'hF2;
        end
        for (int k = 0; k < 4; k++) ram[0][12'h400 + k] = 8'h50 + 8'(k);
        for (int k = 0; k < 16; k++) ram[1][12'h400 + k] = 8'hA0 + 8'(k);

        test_reset();
        test_load_word();
        test_sign_ext();
        test_io_store();
        test_store_word();
        test_rdy_stall();
        test_fair_rr();
        test_fixed_prio();
        test_flush();
        test_back_to_back();
        test_reset_abort();

        checks++;
        if (both_done !== 0) begin
            errors++;
            $display("FAIL exclusive_done: %0d cycles with both pulses, required 0", both_done);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
